// File: rtl/keypad_pkg.sv
// Shared encodings and helpers for the keypad scanner and its event FIFO.
package keypad_pkg;

  // Event kinds carried in the top two bits of every FIFO word
  localparam logic [1:0] KIND_PRESS   = 2'b01;
  localparam logic [1:0] KIND_RELEASE = 2'b10;
  localparam logic [1:0] KIND_REPEAT  = 2'b11;

  // Classification of one complete scan frame
  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_KEY   = 2'd1,
    CLS_MULTI = 2'd2
  } frame_cls_t;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event FIFO with drop-on-full and sticky overflow.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign do_pop    = out_valid && pop_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only ever read behind a valid count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Sticky drop flag; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (push && !do_push) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: column drive, row synchroniser, frame debounce,
// press/release/repeat event generation into a small event FIFO.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter  int NUM_ROWS       = 4,
  parameter  int NUM_COLS       = 4,
  parameter  int SCAN_DIV       = 50000,
  parameter  int DEBOUNCE_SCANS = 4,
  parameter  int REPEAT_SCANS   = 0,
  parameter  int REPORT_RELEASE = 1,
  parameter  int FIFO_DEPTH     = 4,
  localparam int CODE_W         = clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] fila,
  output logic [NUM_COLS-1:0] col,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [CODE_W+1:0]   ev_data,
  output logic                key_down,
  output logic [CODE_W-1:0]   key_code,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int COL_W  = clog2(NUM_COLS);
  localparam int DIV_W  = clog2(SCAN_DIV + 1);
  localparam int STAB_W = clog2(DEBOUNCE_SCANS + 1);
  localparam int REP_W  = clog2(REPEAT_SCANS + 2);

  logic [NUM_ROWS-1:0] fila_s1, fila_s2;
  logic                scan_en;
  logic [COL_W-1:0]    col_idx;
  logic [DIV_W-1:0]    div_cnt;
  logic                slot_end, frame_done;

  logic [1:0]          col_n, base_n, tot_n, acc_n;
  logic [2:0]          sum_n;
  logic [CODE_W-1:0]   col_code, tot_code, acc_code;

  frame_cls_t          res_cls, cand_cls;
  logic [CODE_W-1:0]   res_code, cand_code;
  logic [STAB_W-1:0]   stab_cnt, new_stab;
  logic                differs, accept;
  logic [REP_W-1:0]    rep_cnt;

  logic                push_v, pend_v;
  logic [CODE_W+1:0]   push_d;
  logic [CODE_W-1:0]   pend_code;

  // Two-flop synchroniser on the raw rows (idle level is high)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fila_s1 <= '1;
      fila_s2 <= '1;
    end else begin
      fila_s1 <= fila;
      fila_s2 <= fila_s1;
    end
  end

  assign slot_end   = scan_en && (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_done = slot_end && (col_idx == COL_W'(NUM_COLS - 1));

  // Column slot timer; scan_en holds the columns idle until the first edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_en <= 1'b0;
      col_idx <= '0;
      div_cnt <= '0;
    end else if (!scan_en) begin
      scan_en <= 1'b1;
    end else if (slot_end) begin
      div_cnt <= '0;
      col_idx <= (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Active-low one-hot column drive
  always_comb begin
    col = '1;
    if (scan_en) col[col_idx] = 1'b0;
  end

  // Closed switches in the current column: saturating count and lowest row's code
  always_comb begin
    col_n    = 2'd0;
    col_code = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (!fila_s2[r]) begin
        if (col_n == 2'd0) col_code = CODE_W'(r * NUM_COLS) + CODE_W'(col_idx);
        if (col_n != 2'd2) col_n = col_n + 2'd1;
      end
    end
  end

  // Fold this column into the running frame result; column 0 starts a fresh frame
  always_comb begin
    base_n   = (col_idx == '0) ? 2'd0 : acc_n;
    sum_n    = {1'b0, base_n} + {1'b0, col_n};
    tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    tot_code = (base_n != 2'd0) ? acc_code : col_code;
    res_cls  = (tot_n == 2'd0) ? CLS_NONE : ((tot_n == 2'd1) ? CLS_KEY : CLS_MULTI);
    res_code = (tot_n == 2'd1) ? tot_code : '0;
  end

  // Per-frame accumulator, written at every column sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_n    <= 2'd0;
      acc_code <= '0;
    end else if (slot_end) begin
      acc_n    <= tot_n;
      acc_code <= tot_code;
    end
  end

  // Debounce decision for the frame completing this cycle; MULTI never differs
  always_comb begin
    if ((res_cls == cand_cls) && (res_code == cand_code)) begin
      new_stab = (stab_cnt == STAB_W'(DEBOUNCE_SCANS)) ? stab_cnt : stab_cnt + 1'b1;
    end else begin
      new_stab = STAB_W'(1);
    end
    case (res_cls)
      CLS_NONE: differs = key_down;
      CLS_KEY:  differs = !key_down || (key_code != res_code);
      default:  differs = 1'b0;
    endcase
    accept = frame_done && (new_stab == STAB_W'(DEBOUNCE_SCANS)) && differs;
  end

  // Accepted state, repeat timer and event generation.
  // A key-to-key change queues the press in pend_* so it follows the release by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_cls  <= CLS_NONE;
      cand_code <= '0;
      stab_cnt  <= '0;
      key_down  <= 1'b0;
      key_code  <= '0;
      rep_cnt   <= '0;
      push_v    <= 1'b0;
      push_d    <= '0;
      pend_v    <= 1'b0;
      pend_code <= '0;
    end else begin
      push_v <= 1'b0;
      if (pend_v) begin
        pend_v <= 1'b0;
        push_v <= 1'b1;
        push_d <= {KIND_PRESS, pend_code};
      end
      if (frame_done) begin
        cand_cls  <= res_cls;
        cand_code <= res_code;
        stab_cnt  <= new_stab;
        if (accept) begin
          rep_cnt <= '0;
          if (res_cls == CLS_KEY) begin
            key_down <= 1'b1;
            key_code <= res_code;
            if (key_down && (REPORT_RELEASE != 0)) begin
              push_v    <= 1'b1;
              push_d    <= {KIND_RELEASE, key_code};
              pend_v    <= 1'b1;
              pend_code <= res_code;
            end else begin
              push_v <= 1'b1;
              push_d <= {KIND_PRESS, res_code};
            end
          end else begin
            key_down <= 1'b0;
            if (REPORT_RELEASE != 0) begin
              push_v <= 1'b1;
              push_d <= {KIND_RELEASE, key_code};
            end
          end
        end else if ((REPEAT_SCANS != 0) && key_down) begin
          if (rep_cnt == REP_W'(REPEAT_SCANS - 1)) begin
            rep_cnt <= '0;
            push_v  <= 1'b1;
            push_d  <= {KIND_REPEAT, key_code};
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
      end
    end
  end

  key_event_fifo #(
    .WIDTH (CODE_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_v),
    .push_data (push_d),
    .pop_ready (ev_ready),
    .out_valid (ev_valid),
    .out_data  (ev_data),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Scoreboard bench for keypad_scan_fifo: 4x4 matrix, SCAN_DIV=4 (16-cycle frames).
module tb_keypad_scan_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fila, fila_r, col, col_r;
  logic       ev_valid, ev_valid_r, ev_ready, ev_ready_r;
  logic [5:0] ev_data, ev_data_r;
  logic       key_down, key_down_r;
  logic [3:0] key_code, key_code_r;
  logic       overflow, overflow_r, ovf_clr, ovf_clr_r;

  logic [15:0] keys, keys_r;
  logic [5:0]  exp_q[$];
  logic [5:0]  exp_r_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  keypad_scan_fifo #(
    .NUM_ROWS(4), .NUM_COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS(0), .REPORT_RELEASE(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .fila(fila), .col(col),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .key_down(key_down), .key_code(key_code),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  keypad_scan_fifo #(
    .NUM_ROWS(4), .NUM_COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS(2), .REPORT_RELEASE(0), .FIFO_DEPTH(4)
  ) dut_r (
    .clk(clk), .rst(rst), .fila(fila_r), .col(col_r),
    .ev_valid(ev_valid_r), .ev_ready(ev_ready_r), .ev_data(ev_data_r),
    .key_down(key_down_r), .key_code(key_code_r),
    .overflow(overflow_r), .ovf_clr(ovf_clr_r)
  );

  // Switch matrix: a closed key pulls its row low while its column is driven low
  always_comb begin
    fila   = '1;
    fila_r = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c]   && !col[c])   fila[r]   = 1'b0;
        if (keys_r[r*4+c] && !col_r[c]) fila_r[r] = 1'b0;
      end
    end
  end

  // Monitor: every handshake pops the matching scoreboard entry
  always @(negedge clk) begin : monitor
    logic [5:0] e;
    if (rst && ev_valid && ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ev_unexpected: got %b, required no event", ev_data);
      end else begin
        e = exp_q.pop_front();
        if (ev_data !== e) begin
          errors++;
          $display("FAIL ev_data: got %b, required %b", ev_data, e);
        end
      end
    end
    if (rst && ev_valid_r && ev_ready_r) begin
      checks++;
      if (exp_r_q.size() == 0) begin
        errors++;
        $display("FAIL ev_r_unexpected: got %b, required no event", ev_data_r);
      end else begin
        e = exp_r_q.pop_front();
        if (ev_data_r !== e) begin
          errors++;
          $display("FAIL ev_r_data: got %b, required %b", ev_data_r, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    cycles(16 * n);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || exp_r_q.size() != 0); i++) cycles(1);
    check(name, exp_q.size() + exp_r_q.size(), 0);
  endtask

  initial begin
    logic [3:0] ecol;
    rst = 1'b0; keys = '0; keys_r = '0;
    ev_ready = 1'b1; ev_ready_r = 1'b1; ovf_clr = 1'b0; ovf_clr_r = 1'b0;

    // Reset values
    cycles(3);
    check("rst_col", col, 4'hF);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_data", ev_data, 0);
    check("rst_key_down", key_down, 0);
    check("rst_key_code", key_code, 0);
    check("rst_overflow", overflow, 0);

    // Column sequence after release, two full frames
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      ecol = ~(4'b0001 << ((k / 4) % 4));
      check("col_seq", col, ecol);
    end
    check("idle_ev_valid", ev_valid, 0);
    check("idle_key_down", key_down, 0);

    // Typematic repeat, no release reporting: press 15 then four repeats
    exp_r_q.push_back(6'b01_1111);
    for (int i = 0; i < 4; i++) exp_r_q.push_back(6'b11_1111);
    keys_r[15] = 1'b1;
    frames(10);
    keys_r[15] = 1'b0;
    frames(6);
    check("rep_key_down_after", key_down_r, 0);
    drain("rep_drain");

    // Key 9 press and release
    exp_q.push_back(6'b01_1001);
    exp_q.push_back(6'b10_1001);
    keys[9] = 1'b1;
    frames(5);
    check("k9_key_down", key_down, 1);
    check("k9_key_code", key_code, 9);
    keys[9] = 1'b0;
    frames(5);
    check("k9_released", key_down, 0);
    check("k9_code_hold", key_code, 9);

    // Bounce shorter than the debounce window
    keys[6] = 1'b1;
    cycles(32);
    keys[6] = 1'b0;
    frames(5);
    check("short_key_down", key_down, 0);
    check("short_key_code", key_code, 9);

    // Ghosting: two keys together produce nothing, then key 0 alone
    keys[0] = 1'b1; keys[5] = 1'b1;
    frames(6);
    check("multi_key_down", key_down, 0);
    check("multi_ev_valid", ev_valid, 0);
    exp_q.push_back(6'b01_0000);
    keys[5] = 1'b0;
    cycles(48);
    exp_q.push_back(6'b10_0000);
    keys[0] = 1'b0;
    frames(5);
    check("ghost_key_down", key_down, 0);
    drain("ghost_drain");

    // Overflow: six events into a stalled depth-4 FIFO
    ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      keys[3] = 1'b1; frames(5);
      keys[3] = 1'b0; frames(5);
    end
    check("ovf_set", overflow, 1);
    check("ovf_head_valid", ev_valid, 1);
    check("ovf_head_data", ev_data, 6'b01_0011);
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    exp_q.push_back(6'b01_0011);
    exp_q.push_back(6'b10_0011);
    exp_q.push_back(6'b01_0011);
    exp_q.push_back(6'b10_0011);
    ev_ready = 1'b1;
    drain("ovf_drain");
    check("ovf_empty", ev_valid, 0);

    // Reset mid-scan discards queued events
    ev_ready = 1'b0;
    keys[3] = 1'b1; frames(5);
    keys[3] = 1'b0; frames(5);
    check("pre_rst_valid", ev_valid, 1);
    cycles(2);
    rst = 1'b0;
    #1;
    check("mid_rst_ev_valid", ev_valid, 0);
    check("mid_rst_col", col, 4'hF);
    cycles(2);
    @(negedge clk) rst = 1'b1;
    ev_ready = 1'b1;
    frames(3);
    check("post_rst_ev_valid", ev_valid, 0);
    exp_q.push_back(6'b01_1100);
    exp_q.push_back(6'b10_1100);
    keys[12] = 1'b1; frames(5);
    keys[12] = 1'b0; frames(5);
    drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
